// File: rtl/acr_pkt_if.sv
// rtl/acr_pkt_if.sv - ACR packet handoff between the packet source and the packet scheduler
interface acr_pkt_if;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [23:0]  header;
    logic [223:0] sub;

    modport master (output pkt_valid, header, sub, input pkt_ready);
    modport slave  (input pkt_valid, header, sub, output pkt_ready);
endinterface

// File: rtl/acr_packet_gen.sv
// rtl/acr_packet_gen.sv - HDMI Audio Clock Regeneration packet source
// CTS is the pixel-cycle distance between consecutive windows of N/128 audio strobes.
module acr_packet_gen #(
    parameter int unsigned CTS_WIDTH      = 20,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [2:0]  DEFAULT_RATE   = 3'd2
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       audio_strobe,
    input  logic [2:0] rate_sel,
    acr_pkt_if.master  pkt,
    output logic       audio_locked,
    output logic       overrun,
    output logic       cts_overflow
);
    localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, RUN} state_t;

    state_t               state, state_next;
    logic [2:0]           rate_reg;
    logic [19:0]          n_sel;
    logic [7:0]           w_sel;
    logic [CTS_WIDTH-1:0] cts_cnt;
    logic [CTS_WIDTH-1:0] cts_q;
    logic [7:0]           strb_cnt;
    logic [TO_WIDTH-1:0]  to_cnt;
    logic [19:0]          n_q;
    logic [19:0]          cts_ext;
    logic [55:0]          subpkt;
    logic                 valid_q;
    logic                 in_win, rate_bad, sat, timeout, abort, start, boundary, publish;

    always_comb begin
        n_sel = 20'd6144;
        w_sel = 8'd48;
        case (rate_reg)
            3'd0: begin n_sel = 20'd4096;  w_sel = 8'd32;  end
            3'd1: begin n_sel = 20'd6272;  w_sel = 8'd49;  end
            3'd2: begin n_sel = 20'd6144;  w_sel = 8'd48;  end
            3'd3: begin n_sel = 20'd12544; w_sel = 8'd98;  end
            3'd4: begin n_sel = 20'd12288; w_sel = 8'd96;  end
            3'd5: begin n_sel = 20'd25088; w_sel = 8'd196; end
            3'd6: begin n_sel = 20'd24576; w_sel = 8'd192; end
            default: ;
        endcase
    end

    // Abort outranks a boundary in the same cycle, so a saturated count is never published.
    assign in_win   = (state != IDLE);
    assign rate_bad = (rate_sel != rate_reg) || (rate_sel == 3'd7);
    assign sat      = in_win && (cts_cnt == '1);
    assign timeout  = in_win && !audio_strobe && (to_cnt == TO_LAST);
    assign abort    = rate_bad || timeout || sat;
    assign start    = (state == IDLE) && audio_strobe && !rate_bad;
    assign boundary = in_win && audio_strobe && ((strb_cnt + 8'd1) == w_sel) && !abort;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACQUIRE;
            ACQUIRE: if (abort) state_next = IDLE; else if (boundary) state_next = RUN;
            RUN:     if (abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        audio_locked = (state == RUN);
        publish      = (state == RUN) && boundary;
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            rate_reg <= DEFAULT_RATE;
            cts_cnt  <= '0;
            strb_cnt <= 8'd0;
            to_cnt   <= '0;
        end else begin
            rate_reg <= rate_sel;
            if (!in_win || abort) begin
                cts_cnt  <= '0;
                strb_cnt <= start ? 8'd1 : 8'd0;
                to_cnt   <= '0;
            end else begin
                cts_cnt  <= boundary ? '0 : cts_cnt + CTS_WIDTH'(1);
                strb_cnt <= boundary ? 8'd0 : strb_cnt + {7'd0, audio_strobe};
                to_cnt   <= audio_strobe ? '0 : to_cnt + TO_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            n_q          <= 20'd0;
            cts_q        <= '0;
            overrun      <= 1'b0;
            cts_overflow <= 1'b0;
        end else begin
            if (publish) begin
                n_q     <= n_sel;
                cts_q   <= cts_cnt + CTS_WIDTH'(1);
                valid_q <= 1'b1;
                if (valid_q && !pkt.pkt_ready) overrun <= 1'b1;
            end else if (valid_q && pkt.pkt_ready) begin
                valid_q <= 1'b0;
            end
            if (sat) cts_overflow <= 1'b1;
        end
    end

    assign cts_ext = 20'(cts_q);
    assign subpkt  = {n_q[7:0], n_q[15:8], 4'd0, n_q[19:16],
                      cts_ext[7:0], cts_ext[15:8], 4'd0, cts_ext[19:16], 8'd0};

    assign pkt.pkt_valid = valid_q;
    assign pkt.header    = {8'd0, 8'd0, 8'd1};
    assign pkt.sub       = {4{subpkt}};
endmodule

// File: tb/tb_acr_packet_gen.sv
// tb/tb_acr_packet_gen.sv - directed bench for acr_packet_gen with a reduced CTS width and timeout
module tb_acr_packet_gen;
    logic       clk;
    logic       rst_n;
    logic       strobe;
    logic [2:0] rate_sel;
    logic       locked;
    logic       overrun;
    logic       cts_ovf;
    int         errors = 0;
    int         checks = 0;
    int         acc_cnt = 0;
    int         acc_base;
    logic [223:0] acc_sub = '0;

    localparam logic [55:0] SUB_48K_240  = 56'h00_18_00_F0_00_00_00;
    localparam logic [55:0] SUB_44K_343  = 56'h80_18_00_57_01_00_00;
    localparam logic [55:0] SUB_192K_960 = 56'h00_60_00_C0_03_00_00;

    acr_pkt_if pkt_bus();

    acr_packet_gen #(
        .CTS_WIDTH(10),
        .TIMEOUT_CYCLES(300),
        .DEFAULT_RATE(3'd2)
    ) dut (
        .clk_pixel(clk),
        .rst_n(rst_n),
        .audio_strobe(strobe),
        .rate_sel(rate_sel),
        .pkt(pkt_bus.master),
        .audio_locked(locked),
        .overrun(overrun),
        .cts_overflow(cts_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pkt_bus.pkt_valid && pkt_bus.pkt_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_sub <= pkt_bus.sub;
        end
    end

    task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int period, input int count);
        for (int i = 0; i < count; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            for (int j = 1; j < period; j++) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        strobe = 1'b0;
        rate_sel = 3'd2;
        pkt_bus.pkt_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", pkt_bus.pkt_valid, 1'b0);
        chk("rst_sub", pkt_bus.sub, 224'd0);
        chk("rst_header", pkt_bus.header, 24'h000001);
        chk("rst_locked", locked, 1'b0);
        chk("rst_flags", {overrun, cts_ovf}, 2'b00);
        rst_n = 1'b1;
        tick();

        // 48k: the acquisition window is discarded, the next one is published with CTS=48*5
        strobes(5, 95);
        chk("48k_discard", acc_cnt, 0);
        chk("48k_locked", locked, 1'b1);
        strobes(5, 1);
        chk("48k_first_pkt", acc_cnt, 1);
        chk("48k_sub", acc_sub, {4{SUB_48K_240}});
        strobes(5, 48);
        chk("48k_second_pkt", acc_cnt, 2);
        chk("48k_sub2", acc_sub, {4{SUB_48K_240}});

        // 44.1k: window of 49 strobes, CTS=49*7
        rate_sel = 3'd1;
        tick();
        chk("44k_switch_unlock", locked, 1'b0);
        tick();
        strobes(7, 98);
        chk("44k_pkt", acc_cnt, 3);
        chk("44k_sub", acc_sub, {4{SUB_44K_343}});

        // Back-pressure: pending packet, accept on a boundary, then an overwrite
        pkt_bus.pkt_ready = 1'b0;
        strobes(7, 48);
        chk("pre_boundary_valid", pkt_bus.pkt_valid, 1'b0);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk("latency_valid", pkt_bus.pkt_valid, 1'b1);
        chk("pending_no_overrun", overrun, 1'b0);
        repeat (6) tick();
        strobes(7, 48);
        strobe = 1'b1;
        pkt_bus.pkt_ready = 1'b1;
        tick();
        strobe = 1'b0;
        pkt_bus.pkt_ready = 1'b0;
        chk("accept_boundary_valid", pkt_bus.pkt_valid, 1'b1);
        chk("accept_boundary_overrun", overrun, 1'b0);
        chk("accept_boundary_count", acc_cnt, 4);
        chk("accept_boundary_sub", acc_sub, {4{SUB_44K_343}});
        repeat (6) tick();
        strobes(7, 49);
        chk("overwrite_overrun", overrun, 1'b1);
        chk("overwrite_valid", pkt_bus.pkt_valid, 1'b1);
        pkt_bus.pkt_ready = 1'b1;
        tick();
        chk("drain_valid", pkt_bus.pkt_valid, 1'b0);
        chk("drain_count", acc_cnt, 5);

        // Timeout: last strobe 7 cycles ago, lock drops after 300 strobe-free cycles
        repeat (292) tick();
        chk("timeout_still_locked", locked, 1'b1);
        tick();
        chk("timeout_unlocked", locked, 1'b0);
        strobes(7, 49);
        chk("restart_discard", acc_cnt, 5);
        strobes(7, 49);
        chk("restart_pkt", acc_cnt, 6);
        chk("restart_sub", acc_sub, {4{SUB_44K_343}});

        // Rate switch mid-window to 192k
        strobes(7, 20);
        rate_sel = 3'd6;
        tick();
        chk("switch_unlock", locked, 1'b0);
        strobes(5, 384);
        chk("192k_pkt", acc_cnt, 7);
        chk("192k_sub", acc_sub, {4{SUB_192K_960}});
        chk("192k_locked", locked, 1'b1);

        // Invalid rate code never produces packets
        rate_sel = 3'd7;
        tick();
        strobes(5, 400);
        chk("rate7_no_pkt", acc_cnt, 7);
        chk("rate7_unlocked", locked, 1'b0);
        chk("rate7_no_valid", pkt_bus.pkt_valid, 1'b0);

        // 192 strobes of period 6 exceed the 10-bit counter
        rate_sel = 3'd6;
        tick();
        chk("pre_sat_flag", cts_ovf, 1'b0);
        strobes(6, 400);
        chk("sat_flag", cts_ovf, 1'b1);
        chk("sat_no_pkt", acc_cnt, 7);
        chk("sat_unlocked", locked, 1'b0);

        // Pending packet survives a drop to IDLE
        rate_sel = 3'd2;
        pkt_bus.pkt_ready = 1'b0;
        tick();
        strobes(5, 96);
        chk("pending_valid", pkt_bus.pkt_valid, 1'b1);
        chk("pending_sub", pkt_bus.sub, {4{SUB_48K_240}});
        strobes(5, 20);
        rate_sel = 3'd7;
        tick();
        chk("idle_unlocked", locked, 1'b0);
        chk("idle_keeps_valid", pkt_bus.pkt_valid, 1'b1);
        chk("idle_keeps_sub", pkt_bus.sub, {4{SUB_48K_240}});

        // Asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", pkt_bus.pkt_valid, 1'b0);
        chk("async_rst_sub", pkt_bus.sub, 224'd0);
        chk("async_rst_flags", {overrun, cts_ovf, locked}, 3'b000);
        chk("async_rst_header", pkt_bus.header, 24'h000001);
        tick();
        rate_sel = 3'd2;
        pkt_bus.pkt_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        acc_base = acc_cnt;
        strobes(5, 96);
        chk("post_rst_pkt", acc_cnt, acc_base + 1);
        chk("post_rst_sub", acc_sub, {4{SUB_48K_240}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acr_packet_gen.md
Name: acr_packet_gen

Overview:
- Single-clock, runtime-configurable HDMI Audio Clock Regeneration (ACR) packet source, per HDMI 1.4b Section 5.3.3.
- Measures CTS by counting clk_pixel cycles across a window of N/128 audio sample strobes.
- Publishes the packet to the packet scheduler through a valid/ready handshake.
- Supports seven audio rates with lock tracking, overrun reporting and a strobe timeout.

Parameters:
- CTS_WIDTH, 20, width of the CTS counter and field; must be ≤ 20.
- TIMEOUT_CYCLES, 65535, clk_pixel cycles without a strobe before lock is dropped.
- DEFAULT_RATE, 3'd2, rate_sel code that is assumed out of reset.

Ports:
- clk_pixel  in  1  TMDS pixel clock; the only clock.
- rst_n  in  1  Asynchronous, active-low reset.
- audio_strobe  in  1  One-cycle pulse per audio sample, already in the clk_pixel domain.
- rate_sel  in  3  Rate code: 0=32k N4096, 1=44.1k N6272, 2=48k N6144, 3=88.2k N12544, 4=96k N12288, 5=176.4k N25088, 6=192k N24576, 7=invalid.
- pkt_valid  out  1  Packet pending.
- pkt_ready  in  1  Scheduler accepts the packet in a cycle where pkt_valid&pkt_ready.
- header  out  24  {8'd0,8'd0,8'd1}.
- sub  out  224  Four identical 56-bit subpackets, sub[56i+55:56i] = {N[7:0],N[15:8],{4'd0,N[19:16]},CTS[7:0],CTS[15:8],{4'd0,CTS[19:16]},8'd0}.
- audio_locked  out  1  High in RUN.
- overrun  out  1  Sticky; set when a pending packet is overwritten.
- cts_overflow  out  1  Sticky; set when the CTS counter saturates.

Behaviour:
- Reset values: all outputs 0 except header (constant). Internal state IDLE; rate register loads DEFAULT_RATE.
- Window length W = N/128 strobes: 32, 49, 48, 98, 96, 196, 192. Strobe counter is 8 bits.
- The CTS counter increments every cycle and saturates at all-ones.
- Window boundary: the cycle carrying the W-th strobe.
  - Measured CTS = counter+1; counter then clears to 0.
  - CTS therefore equals the pixel-cycle distance between consecutive boundaries.
- State machine:
  - IDLE: counters held at 0. The first strobe with a valid rate_sel → ACQUIRE, and the strobe counter starts at 1.
  - ACQUIRE: the first boundary is discarded because the window is partial → RUN. Counters restart at that boundary.
  - RUN: each boundary latches {N, CTS} into the output registers and sets pkt_valid on the next cycle (1-cycle latency).
- Any state → IDLE, with counters cleared and audio_locked=0, when any of these occurs:
  - rate_sel differs from its registered value, or rate_sel==7;
  - TIMEOUT_CYCLES consecutive cycles pass with no strobe;
  - the CTS counter saturates (also sets cts_overflow; the saturated value is never published).
- Handshake:
  - header/sub hold stable while pkt_valid=1.
  - pkt_valid falls the cycle after acceptance unless a new boundary lands in that same cycle.
- Simultaneous events:
  - Accept and boundary in the same cycle: the old packet is accepted, the new one loads, pkt_valid stays 1, and overrun is not set.
  - Boundary while pkt_valid=1 with no accept: the new packet overwrites the old one and overrun is set.
- Falling to IDLE does not clear a pending packet. It stays valid with its latched N/CTS until accepted.
- Sticky flags clear only on reset.
- Reset mid-window: everything returns to reset values immediately (asynchronous); no partial CTS is ever published.

Test Plan:
- Rate 48k, strobe every 525 cycles, pkt_ready=1 → the first boundary is discarded. Each later packet has N=6144, CTS=25200 (48×525), sub[55:0]=56'h00_18_00_70_62_00_00, audio_locked=1.
- Rate 44.1k, strobe every 571 cycles → N=6272, CTS=27979 (49×571), window of 49 strobes.
- pkt_ready=0 across two boundaries → the second packet replaces the first and overrun=1. Then assert pkt_ready on a boundary cycle → pkt_valid stays 1 and no further overrun occurs.
- Strobes stop for 65535 cycles → audio_locked=0 at cycle 65535. Restarting strobes → one discarded window, then valid packets resume.
- rate_sel switches 2→6 mid-window → the state goes to IDLE then ACQUIRE. The next published packet has N=24576 and CTS=192×period. rate_sel=7 → no packets are produced.
- Strobe period 6000 at rate 6 with CTS_WIDTH=20 → the counter saturates at 2^20−1, cts_overflow=1, and nothing is published. Assert rst_n low mid-window → all outputs are 0 on the same edge.
